// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: function codes, FSM state type and
// the legal-code decode used to flag reserved ALU operations.
// Imported by alu_arbiter; rr_arbiter is kept generic and does not need it.
package alu_pkg;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] SLL = 4'b1000;
  localparam logic [3:0] SRL = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_e;

  // True for the six function codes the ALU implements; everything else is
  // reserved and still forwarded, but reported back as illegal.
  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    logic legal;
    legal = 1'b0;
    case (ctrl)
      ADD, SUB, AND, OR, SLL, SRL: legal = 1'b1;
      default:                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate: first set req bit at or above ptr, wrapping.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: en=0 suppresses all grants; the caller owns the pointer.
//
// Ports:
//   req        request vector, one bit per requester
//   ptr        highest-priority index (must be < NUM_REQ)
//   en         grant enable
//   grant      one-hot grant (all zero when en=0 or no request)
//   grant_idx  binary index of the granted requester
//   any        a grant was issued
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // One extra bit so ptr+i never overflows before the wrap subtraction;
  // this also keeps non-power-of-2 NUM_REQ wrapping at NUM_REQ-1 -> 0.
  logic [IDX_W:0] pos;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      if (en && !found && req[pos[IDX_W-1:0]]) begin
        found                  = 1'b1;
        grant[pos[IDX_W-1:0]]  = 1'b1;
        grant_idx              = pos[IDX_W-1:0];
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, round-robin.
// Latency: grant -> rsp_valid 2 cycles; at most one op per 3 cycles.
// Backpressure: response held until rsp_ready; no new grants meanwhile.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      per-requester request, one-hot accept pulse
//   req_i_1, req_i_2           packed operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_alu_ctrl               packed function codes, requester k at [k*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH]
//   alu_i_1, alu_i_2, alu_ctrl registered operands/control to the ALU
//   alu_o, alu_*_flag          ALU result and flags
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_o, rsp_*       originating requester, captured result and flags
//   rsp_illegal                function code was not one the ALU implements
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_i_1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_i_2,
  input  logic [NUM_REQ*ALU_CTRL_WIDTH-1:0]   req_alu_ctrl,
  output logic [DATA_WIDTH-1:0]               alu_i_1,
  output logic [DATA_WIDTH-1:0]               alu_i_2,
  output logic [ALU_CTRL_WIDTH-1:0]           alu_ctrl,
  input  logic [DATA_WIDTH-1:0]               alu_o,
  input  logic                                alu_zero_flag,
  input  logic                                alu_overflow_flag,
  input  logic                                alu_exception_flag,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_o,
  output logic                                rsp_zero_flag,
  output logic                                rsp_overflow_flag,
  output logic                                rsp_exception_flag,
  output logic                                rsp_illegal
);

  localparam int IDX_W = $clog2(NUM_REQ);

  alu_arb_state_e            state;
  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          id_q;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_any;
  logic                      arb_en;
  logic [DATA_WIDTH-1:0]     sel_i_1;
  logic [DATA_WIDTH-1:0]     sel_i_2;
  logic [ALU_CTRL_WIDTH-1:0] sel_ctrl;

  // Grants are also held off while reset is asserted: the accept pulse would
  // otherwise tell a requester its op was taken just before it is dropped.
  assign arb_en = rst_n && (state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready = grant;

  // One-hot operand mux driven by the grant vector (constant slice bases).
  always_comb begin
    sel_i_1  = '0;
    sel_i_2  = '0;
    sel_ctrl = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_i_1  = req_i_1[k*DATA_WIDTH +: DATA_WIDTH];
        sel_i_2  = req_i_2[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ctrl = req_alu_ctrl[k*ALU_CTRL_WIDTH +: ALU_CTRL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      ptr                <= '0;
      id_q               <= '0;
      alu_i_1            <= '0;
      alu_i_2            <= '0;
      alu_ctrl           <= '0;
      rsp_valid          <= 1'b0;
      rsp_id             <= '0;
      rsp_o              <= '0;
      rsp_zero_flag      <= 1'b0;
      rsp_overflow_flag  <= 1'b0;
      rsp_exception_flag <= 1'b0;
      rsp_illegal        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_i_1  <= sel_i_1;
            alu_i_2  <= sel_i_2;
            alu_ctrl <= sel_ctrl;
            id_q     <= grant_idx;
            ptr      <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            state    <= EXEC;
          end
        end
        EXEC: begin
          // alu_* have been stable for a full cycle; sample the ALU here.
          rsp_o              <= alu_o;
          rsp_zero_flag      <= alu_zero_flag;
          rsp_overflow_flag  <= alu_overflow_flag;
          rsp_exception_flag <= alu_exception_flag;
          rsp_illegal        <= !is_legal_ctrl(alu_ctrl);
          rsp_id             <= id_q;
          rsp_valid          <= 1'b1;
          state              <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and scoreboard.
// Directed scenarios first, then randomized traffic with random backpressure.
// A negedge monitor compares every cycle against the reference model.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_i_1;
  logic [NREQ*DW-1:0]   req_i_2;
  logic [NREQ*CW-1:0]   req_alu_ctrl;
  logic [DW-1:0]        alu_i_1;
  logic [DW-1:0]        alu_i_2;
  logic [CW-1:0]        alu_ctrl;
  logic [DW-1:0]        alu_o;
  logic                 alu_zero_flag;
  logic                 alu_overflow_flag;
  logic                 alu_exception_flag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [DW-1:0]        rsp_o;
  logic                 rsp_zero_flag;
  logic                 rsp_overflow_flag;
  logic                 rsp_exception_flag;
  logic                 rsp_illegal;

  alu_arbiter #(
    .NUM_REQ        (NREQ),
    .DATA_WIDTH     (DW),
    .ALU_CTRL_WIDTH (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_i_1            (req_i_1),
    .req_i_2            (req_i_2),
    .req_alu_ctrl       (req_alu_ctrl),
    .alu_i_1            (alu_i_1),
    .alu_i_2            (alu_i_2),
    .alu_ctrl           (alu_ctrl),
    .alu_o              (alu_o),
    .alu_zero_flag      (alu_zero_flag),
    .alu_overflow_flag  (alu_overflow_flag),
    .alu_exception_flag (alu_exception_flag),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_id             (rsp_id),
    .rsp_o              (rsp_o),
    .rsp_zero_flag      (rsp_zero_flag),
    .rsp_overflow_flag  (rsp_overflow_flag),
    .rsp_exception_flag (rsp_exception_flag),
    .rsp_illegal        (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU: {o, zero, overflow, exception}. Reserved codes give 0.
  function automatic logic [34:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o;
    logic        ov;
    logic        ex;
    o = '0; ov = 1'b0; ex = 1'b0;
    case (c)
      4'b0010: begin o = a + b; ov = (a[31] == b[31]) && (o[31] != a[31]); end
      4'b0110: begin o = a - b; ov = (a[31] != b[31]) && (o[31] != a[31]); end
      4'b0000: o = a & b;
      4'b0001: o = a | b;
      4'b1000: o = a << b[4:0];
      4'b1001: o = a >> b[4:0];
      default: ex = 1'b1;
    endcase
    return {o, (o == 32'd0), ov, ex};
  endfunction

  function automatic logic ref_legal(input logic [3:0] c);
    return (c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1000, 4'b1001});
  endfunction

  always_comb begin
    {alu_o, alu_zero_flag, alu_overflow_flag, alu_exception_flag} = ref_alu(alu_ctrl, alu_i_1, alu_i_2);
  end

  // Reference model state: one op outstanding at most; age counts cycles
  // since its grant, the response shows up when age reaches 2.
  int          m_ptr = 0;
  bit          m_pend = 0;
  int          m_age = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [3:0]  m_c = '0;
  int          m_pid = 0;
  logic [35:0] m_pres = '0;          // {o, z, ov, ex, ill} of the in-flight op
  int          m_cid = 0;
  logic [35:0] m_cres = '0;          // what the rsp_* registers should show
  int          grant_log[$];
  int          rsp_log[$];

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int w;
    int k;
    exp_rdy = '0;
    w = -1;
    if (rst_n && !m_pend) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (w < 0 && req_valid[k]) w = k;
      end
    end
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
    chk("rsp_valid", rsp_valid, (m_pend && m_age == 2));
    chk("alu_in", {alu_ctrl, alu_i_1, alu_i_2}, {m_c, m_a, m_b});
    chk("rsp_id", rsp_id, m_cid);
    chk("rsp_fields", {rsp_o, rsp_zero_flag, rsp_overflow_flag, rsp_exception_flag, rsp_illegal}, m_cres);
    if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));

    if (!rst_n) begin
      m_pend = 0; m_age = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_c = '0;
      m_cid = 0; m_cres = '0;
    end else if (!m_pend) begin
      if (w >= 0) begin
        m_pend = 1; m_age = 1;
        m_ptr  = (w + 1) % NREQ;
        m_a    = req_i_1[w*DW +: DW];
        m_b    = req_i_2[w*DW +: DW];
        m_c    = req_alu_ctrl[w*CW +: CW];
        m_pid  = w;
        m_pres = {ref_alu(m_c, m_a, m_b), !ref_legal(m_c)};
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_cid  = m_pid;
      m_cres = m_pres;
    end else if (rsp_ready) begin
      m_pend = 0;
    end
  end

  // Inputs only ever change here, 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_alu_ctrl[k*CW +: CW] = c;
    req_i_1[k*DW +: DW]      = a;
    req_i_2[k*DW +: DW]      = b;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int t = 0; t < 20 && g < 0; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
    end
    if (g < 0) chk("grant_timeout", |req_ready, 1'b1);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1'b1);
  endtask

  // Issue one op from requester k alone and stop at the first rsp_valid cycle.
  task automatic run_op(input int k, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
    int g;
    cyc();
    set_op(k, c, a, b);
    req_valid = 4'b0001 << k;
    wait_grant(g);
    chk("grant_id", g, k);
    cyc();
    req_valid = '0;
    wait_rsp(lat);
  endtask

  initial begin
    int g, lat, n0;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_i_1 = '0; req_i_2 = '0; req_alu_ctrl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {req_ready, rsp_valid, alu_i_1, alu_ctrl, rsp_o, rsp_illegal}, '0);
    cyc();
    rst_n = 1'b1;

    // Round-robin with all four requesting AND.
    for (int k = 0; k < NREQ; k++) set_op(k, 4'b0000, 32'hFF00_FF00 ^ (32'h1111_1111 * k), 32'h0F0F_F0F0 + k);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    grant_log.delete();
    rsp_log.delete();
    for (int t = 0; t < 40 && grant_log.size() < 5; t++) @(negedge clk);
    cyc();
    req_valid = '0;
    for (int t = 0; t < 20 && rsp_log.size() < 5; t++) @(negedge clk);
    chk("rr_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", (i < grant_log.size()) ? grant_log[i] : -1, i % NREQ);
      chk("rr_rsp_id", (i < rsp_log.size()) ? rsp_log[i] : -1, i % NREQ);
    end

    // Single request: 5 + 7.
    n0 = grant_log.size();
    run_op(0, 4'b0010, 32'd5, 32'd7, lat);
    chk("single_lat", lat, 2);
    chk("single_o", rsp_o, 32'd12);
    chk("single_id", rsp_id, 2'd0);
    chk("single_flags", {rsp_zero_flag, rsp_overflow_flag, rsp_exception_flag, rsp_illegal}, 4'b0000);
    chk("single_grants", grant_log.size() - n0, 1);

    // Backpressure: 3 - 3 held for six cycles, other requesters waiting.
    cyc();
    rsp_ready = 1'b0;
    set_op(2, 4'b0110, 32'd3, 32'd3);
    req_valid = 4'b0100;
    wait_grant(g);
    cyc();
    req_valid = 4'b1111;
    wait_rsp(lat);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_o_zero", {rsp_o, rsp_zero_flag}, {32'd0, 1'b1});
      chk("bp_no_grant", req_ready, 4'b0000);
    end
    cyc();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_resume", |req_ready, 1'b1);
    cyc();
    req_valid = '0;
    wait_rsp(lat);

    // Signed overflow, then shift into the sign bit.
    run_op(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
    chk("ovf_o", rsp_o, 32'h8000_0000);
    chk("ovf_flag", rsp_overflow_flag, 1'b1);
    run_op(3, 4'b1000, 32'd1, 32'd31, lat);
    chk("sll_o", rsp_o, 32'h8000_0000);

    // Reserved function code.
    run_op(2, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("ill_o", rsp_o, 32'd0);
    chk("ill_zero", rsp_zero_flag, 1'b1);
    chk("ill_flag", rsp_illegal, 1'b1);

    // Reset while the ALU op is executing.
    cyc();
    for (int k = 0; k < NREQ; k++) set_op(k, 4'b0001, 32'hA5A5_0000 + k, 32'h0000_5A5A);
    req_valid = 4'b1111;
    wait_grant(g);
    cyc();
    rst_n = 1'b0;
    req_valid = '0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_alu", {alu_ctrl, alu_i_1, alu_i_2}, '0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_o, rsp_zero_flag, rsp_overflow_flag, rsp_exception_flag, rsp_illegal}, '0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 1'b0);
    end
    cyc();
    req_valid = 4'b1111;
    wait_grant(g);
    chk("rst_first_grant", g, 0);
    cyc();
    req_valid = '0;
    wait_rsp(lat);

    // Randomized traffic and backpressure.
    for (int t = 0; t < 600; t++) begin
      cyc();
      req_valid = NREQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NREQ; k++) begin
        set_op(k, 4'($urandom_range(0, 15)), $urandom(), ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)));
      end
    end
    cyc();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
